// File: rtl/bus_xfer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bus_xfer_pkg
// Description : Shared types and default constants for the bus transfer
//               sequencer: FSM state encoding, default sizing, and the
//               default-width command record queued by cmd_fifo.
// Revision    : 1.0  initial release
// ============================================================================
package bus_xfer_pkg;

    localparam int DEF_SEL_W      = 3;
    localparam int DEF_NUM_REGS   = 8;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LATCH = 2'd2
    } state_t;

    // Default-width command record; the top level builds its own record of
    // the same shape when SEL_W differs from the default.
    typedef struct packed {
        logic [DEF_SEL_W-1:0] src;
        logic [DEF_SEL_W-1:0] dst;
    } cmd_t;

endpackage : bus_xfer_pkg
`default_nettype wire

// File: rtl/bus_xfer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface   : bus_xfer_ctrl_if
// Description : Command handshake and register-control lines of the bus
//               transfer sequencer.
//   cmd_valid / cmd_ready / cmd_src / cmd_dst : command offer handshake
//   enable / load                             : per-register drive / capture
//   busy / done / err                         : status
//   master modport : command issuer;  slave modport : sequencer
// Revision    : 1.0  initial release
// ============================================================================
interface bus_xfer_ctrl_if
    import bus_xfer_pkg::*;
#(
    parameter int SEL_W    = DEF_SEL_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) ();

    logic                cmd_valid;
    logic                cmd_ready;
    logic [SEL_W-1:0]    cmd_src;
    logic [SEL_W-1:0]    cmd_dst;
    logic [NUM_REGS-1:0] enable;
    logic [NUM_REGS-1:0] load;
    logic                busy;
    logic                done;
    logic                err;

    modport master (
        output cmd_valid, cmd_src, cmd_dst,
        input  cmd_ready, enable, load, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_src, cmd_dst,
        output cmd_ready, enable, load, busy, done, err
    );

endinterface : bus_xfer_ctrl_if
`default_nettype wire

// File: rtl/bus_xfer_ctrl_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cmd_fifo
// Description : Synchronous FIFO of command records with full/empty/count.
//   clk, rst_n : clock, synchronous active-low reset (empties the queue)
//   i_push, i_data : write request and data (ignored while full)
//   i_pop, o_data  : read request and head-of-queue data (ignored while empty)
//   o_full, o_empty, o_count : occupancy status
// Revision    : 1.0  initial release
// ============================================================================
module cmd_fifo
    import bus_xfer_pkg::*;
#(
    parameter int  DEPTH = DEF_FIFO_DEPTH,
    parameter type T     = cmd_t
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     i_push,
    input  wire T                         i_data,
    input  wire logic                     i_pop,
    output T                              o_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(DEPTH):0]        o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    T               r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           w_push;
    logic           w_pop;

    assign o_full  = (r_count == C_DEPTH);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop  && !o_empty;

    // Storage needs no reset: only entries covered by r_count are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : cmd_fifo
`default_nettype wire

// File: rtl/bus_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bus_xfer_ctrl
// Description : Sequencer for a shared 8-bit tri-state bus. Queues legal
//               src->dst transfer commands and executes them one at a time
//               (DRIVE settle cycle, then LATCH capture cycle), so at most
//               one register ever drives the bus.
//   clk   : clock (posedge)
//   rst_n : synchronous active-low reset
//   bus   : bus_xfer_ctrl_if.slave -- command handshake, enable/load lines,
//           busy/done/err status
// Revision    : 1.0  initial release
// ============================================================================
module bus_xfer_ctrl
    import bus_xfer_pkg::*;
#(
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int SEL_W      = DEF_SEL_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    bus_xfer_ctrl_if.slave  bus
);

    typedef struct packed {
        logic [SEL_W-1:0] src;
        logic [SEL_W-1:0] dst;
    } xfer_t;

    // One extra bit so that NUM_REGS == 2**SEL_W is representable.
    localparam logic [SEL_W:0] C_NUM_REGS = (SEL_W+1)'(NUM_REGS);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [SEL_W-1:0]            r_cur_src;
    logic [SEL_W-1:0]            r_cur_dst;
    logic                        r_err;

    logic                        w_accept;
    logic                        w_illegal;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_fifo_full;
    logic                        w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
    xfer_t                       w_push_cmd;
    xfer_t                       w_head;

    logic [NUM_REGS-1:0]         w_src_dec;
    logic [NUM_REGS-1:0]         w_dst_dec;
    logic [NUM_REGS-1:0]         w_enable;
    logic [NUM_REGS-1:0]         w_load;
    logic                        w_done;

    // ------------------------------------------------------------------
    // Command acceptance and legality
    // ------------------------------------------------------------------
    assign bus.cmd_ready = !w_fifo_full;
    assign w_accept      = bus.cmd_valid && bus.cmd_ready;

    assign w_illegal = (bus.cmd_src == bus.cmd_dst)
                    || ({1'b0, bus.cmd_src} >= C_NUM_REGS)
                    || ({1'b0, bus.cmd_dst} >= C_NUM_REGS);

    // Illegal commands are consumed from the handshake but never queued.
    assign w_push         = w_accept && !w_illegal;
    assign w_push_cmd.src = bus.cmd_src;
    assign w_push_cmd.dst = bus.cmd_dst;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (xfer_t)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_cmd),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // ------------------------------------------------------------------
    // Transfer FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cur_src <= '0;
            r_cur_dst <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_accept && w_illegal;
            if (w_pop) begin
                r_cur_src <= w_head.src;
                r_cur_dst <= w_head.dst;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transfer FSM: next state and pop. LATCH pops directly into DRIVE so
    // that back-to-back transfers need no idle turnaround cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                w_state_nxt = LATCH;
            end
            LATCH: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = DRIVE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // One-hot decoders of the current transfer's register indices
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
        assign w_src_dec[gi] = (r_cur_src == SEL_W'(gi));
        assign w_dst_dec[gi] = (r_cur_dst == SEL_W'(gi));
    end

    // Outputs come only from registered state, so no cmd_* input can
    // glitch an enable or load line.
    always_comb begin
        w_enable = '0;
        w_load   = '0;
        w_done   = 1'b0;
        case (r_state)
            DRIVE: begin
                w_enable = w_src_dec;
            end
            LATCH: begin
                w_enable = w_src_dec;
                w_load   = w_dst_dec;
                w_done   = 1'b1;
            end
            default: begin
                w_enable = '0;
            end
        endcase
    end

    assign bus.enable = w_enable;
    assign bus.load   = w_load;
    assign bus.done   = w_done;
    assign bus.err    = r_err;
    assign bus.busy   = (w_fifo_count != '0) || (r_state != IDLE);

endmodule : bus_xfer_ctrl
`default_nettype wire

// File: tb/tb_bus_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_xfer_ctrl
// Description : Directed self-checking bench for bus_xfer_ctrl. Models an
//               8-entry register file driven by the enable/load lines and
//               keeps an in-order scoreboard of expected register contents.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bus_xfer_ctrl;

    localparam int SEL_W      = 4;
    localparam int NUM_REGS   = 8;
    localparam int FIFO_DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_xfer_ctrl_if #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) bus ();

    bus_xfer_ctrl #(
        .NUM_REGS   (NUM_REGS),
        .SEL_W      (SEL_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- register file model ----------------
    logic [7:0] regs     [NUM_REGS];
    logic [7:0] exp_regs [NUM_REGS];
    logic       pre_we  = 1'b0;
    int         pre_idx = 0;
    logic [7:0] pre_val = 8'h00;
    logic [7:0] bus_val;

    always_comb begin
        bus_val = 8'h00;
        for (int i = 0; i < NUM_REGS; i++)
            if (bus.enable[i]) bus_val = bus_val | regs[i];
    end

    always @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++)
            if (bus.load[i]) regs[i] <= bus_val;
        if (pre_we) regs[pre_idx] <= pre_val;
    end

    // ---------------- cycle counter / done recorder ----------------
    int   cyc = 0;
    int   done_q[$];
    logic rec_en = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rec_en && bus.done) done_q.push_back(cyc);

    // ---------------- per-cycle bus invariant ----------------
    logic inv_en = 1'b0;
    function automatic logic inv_ok();
        return ($countones(bus.enable) <= 1) && ($countones(bus.load) <= 1)
            && ((bus.enable & bus.load) == '0) && (bus.done == (bus.load != '0));
    endfunction
    always @(negedge clk) if (inv_en) chk("invariant", {31'b0, inv_ok()}, 32'd1);

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic preset(input int i, input logic [7:0] v);
        pre_we  = 1'b1;
        pre_idx = i;
        pre_val = v;
        exp_regs[i] = v;
        step();
        pre_we = 1'b0;
    endtask

    function automatic bit legal(input int s, input int d);
        return (s != d) && (s < NUM_REGS) && (d < NUM_REGS);
    endfunction

    task automatic sb_copy(input int s, input int d);
        exp_regs[d] = exp_regs[s];
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NUM_REGS; i++)
            chk($sformatf("%s[%0d]", tag, i), {24'b0, regs[i]}, {24'b0, exp_regs[i]});
    endtask

    // Offers a command and returns at the negedge after the accepting edge.
    task automatic send(input int s, input int d);
        bit acc = 1'b0;
        int w   = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_src   = SEL_W'(s);
        bus.cmd_dst   = SEL_W'(d);
        while (!acc && w < 40) begin
            acc = bus.cmd_ready;
            step();
            w++;
        end
        bus.cmd_valid = 1'b0;
        chk("send_accept", {31'b0, acc}, 32'd1);
        chk("send_err", {31'b0, bus.err}, {31'b0, !legal(s, d)});
    endtask

    task automatic drain();
        int n = 0;
        while (bus.busy && n < 60) begin
            step();
            n++;
        end
        chk("drain_idle", {31'b0, bus.busy}, 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_enable"}, {24'b0, bus.enable}, 32'd0);
        chk({tag, "_load"},   {24'b0, bus.load},   32'd0);
        chk({tag, "_done"},   {31'b0, bus.done},   32'd0);
        chk({tag, "_err"},    {31'b0, bus.err},    32'd0);
        chk({tag, "_busy"},   {31'b0, bus.busy},   32'd0);
        chk({tag, "_ready"},  {31'b0, bus.cmd_ready}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int   c0;
        int   idx;
        int   s;
        int   d;
        int   ft_src [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
        int   ft_dst [8] = '{1, 2, 3, 4, 5, 6, 7, 0};
        logic [9:0] rdy_pat;

        bus.cmd_valid = 1'b0;
        bus.cmd_src   = '0;
        bus.cmd_dst   = '0;

        // Reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;
        step();
        check_quiet("post_reset");
        inv_en = 1'b1;

        for (int i = 0; i < NUM_REGS; i++) preset(i, 8'(8'h11 * (i + 1)));

        // Single transfer 2 -> 5
        preset(2, 8'h5A);
        send(2, 5);
        sb_copy(2, 5);
        chk("t1_idle_enable", {24'b0, bus.enable}, 32'h00);
        chk("t1_busy", {31'b0, bus.busy}, 32'd1);
        step();
        chk("t1_drive_enable", {24'b0, bus.enable}, 32'h04);
        chk("t1_drive_load",   {24'b0, bus.load},   32'h00);
        chk("t1_drive_done",   {31'b0, bus.done},   32'd0);
        step();
        chk("t1_latch_enable", {24'b0, bus.enable}, 32'h04);
        chk("t1_latch_load",   {24'b0, bus.load},   32'h20);
        chk("t1_latch_done",   {31'b0, bus.done},   32'd1);
        step();
        chk("t1_reg5", {24'b0, regs[5]}, 32'h5A);
        chk("t1_done_low", {31'b0, bus.done}, 32'd0);
        chk("t1_busy_low", {31'b0, bus.busy}, 32'd0);

        // Back-to-back chain 1->3->4->6->7->0
        preset(1, 8'hC3);
        done_q.delete();
        rec_en = 1'b1;
        send(1, 3); c0 = cyc; sb_copy(1, 3);
        send(3, 4); sb_copy(3, 4);
        send(4, 6); sb_copy(4, 6);
        send(6, 7); sb_copy(6, 7);
        send(7, 0); sb_copy(7, 0);
        drain();
        rec_en = 1'b0;
        chk("t2_done_count", done_q.size(), 32'd5);
        for (int k = 0; k < 5; k++)
            if (k < done_q.size())
                chk($sformatf("t2_done_cycle_%0d", k), done_q[k], c0 + 2 + 2 * k);
        chk("t2_reg0", {24'b0, regs[0]}, 32'hC3);
        check_regs("t2_reg");

        // Illegal commands
        send(3, 3);
        chk("t3a_busy",   {31'b0, bus.busy},   32'd0);
        chk("t3a_enable", {24'b0, bus.enable}, 32'h00);
        step();
        chk("t3a_err_clear", {31'b0, bus.err}, 32'd0);
        send(9, 2);
        chk("t3b_busy", {31'b0, bus.busy}, 32'd0);
        chk("t3b_load", {24'b0, bus.load}, 32'h00);
        step();
        chk("t3b_err_clear", {31'b0, bus.err}, 32'd0);
        send(1, 8);
        chk("t3c_busy", {31'b0, bus.busy}, 32'd0);
        step();
        chk("t3c_err_clear", {31'b0, bus.err}, 32'd0);
        check_regs("t3_reg");

        // Reset during the first DRIVE: nothing loaded, queue dropped
        for (int i = 0; i < NUM_REGS; i++) preset(i, 8'(8'h20 + 8'h07 * i));
        send(0, 1);
        send(2, 3);
        chk("t4_drive_enable", {24'b0, bus.enable}, 32'h01);
        bus.cmd_valid = 1'b1;
        bus.cmd_src   = SEL_W'(4);
        bus.cmd_dst   = SEL_W'(5);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.cmd_valid = 1'b0;
        check_quiet("t4_after_reset");
        repeat (3) step();
        chk("t4_busy", {31'b0, bus.busy}, 32'd0);
        check_regs("t4_reg");

        // Reset during LATCH: that transfer still lands
        send(6, 7);
        step();
        step();
        chk("t4b_latch_done", {31'b0, bus.done}, 32'd1);
        chk("t4b_latch_load", {24'b0, bus.load}, 32'h80);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        sb_copy(6, 7);
        chk("t4b_reg7", {24'b0, regs[7]}, {24'b0, exp_regs[7]});
        check_quiet("t4b_after_reset");

        // Full boundary with cmd_valid held high
        for (int i = 0; i < NUM_REGS; i++) preset(i, 8'(8'hA0 + i));
        rdy_pat = 10'b01_0111_1111;
        idx = 0;
        for (int k = 0; k < 10; k++) begin
            if (idx < 8) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_src   = SEL_W'(ft_src[idx]);
                bus.cmd_dst   = SEL_W'(ft_dst[idx]);
            end else begin
                bus.cmd_valid = 1'b0;
            end
            chk($sformatf("t5_ready_%0d", k), {31'b0, bus.cmd_ready}, {31'b0, rdy_pat[k]});
            if (bus.cmd_ready && idx < 8) begin
                sb_copy(ft_src[idx], ft_dst[idx]);
                idx++;
            end
            step();
        end
        bus.cmd_valid = 1'b0;
        chk("t5_accepted", idx, 32'd8);
        drain();
        check_regs("t5_reg");

        // Random stream of 1000 commands
        for (int n = 0; n < 1000; n++) begin
            if (n % 200 == 0) begin
                drain();
                check_regs("t6_reg");
                for (int i = 0; i < NUM_REGS; i++) preset(i, 8'($urandom_range(0, 255)));
            end
            s = int'($urandom_range(0, 9));
            d = int'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) step();
            send(s, d);
            if (legal(s, d)) sb_copy(s, d);
        end
        drain();
        check_regs("t6_final");

        inv_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_bus_xfer_ctrl
`default_nettype wire
